// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_pkg: shared FSM encodings, line-level bit values and the even-parity check for serial_frame_rx
package serial_frame_pkg;
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  localparam logic START_BIT = 1'b1, STOP_BIT = 1'b0;
  function automatic logic even_ok(input logic [31:0] word, input logic par);
    return ~^{word, par};
  endfunction
endpackage

// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial input, output word handshake and status pulses; master = receiver, slave = upstream/consumer side
interface serial_frame_rx_if #(parameter int DATA_W = 8);
  logic si;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic frame_err;
  logic overrun;
  logic parity_err;
  modport master(input si, out_ready, output out_data, out_valid, busy, frame_err, overrun, parity_err);
  modport slave(output si, out_ready, input out_data, out_valid, busy, frame_err, overrun, parity_err);
endinterface

// File: rtl/serial_frame_rx_hold.sv
// rx_hold_reg: one-entry valid/ready output buffer; ports clk, rst, load, load_data, out_ready -> out_data, out_valid, full
module rx_hold_reg #(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              full
);
  // full means a word is held that is not being taken this cycle
  assign full = out_valid && !out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/MSB-first data/[parity]/stop frame receiver; ports clk, rst, bus (serial_frame_rx_if.master); optional PARITY_CHECK_EN
module serial_frame_rx import serial_frame_pkg::*; #(parameter int DATA_W = 8) (
  input logic clk,
  input logic rst,
  serial_frame_rx_if.master bus
);
  localparam int CW = $clog2(DATA_W);
  logic [1:0] state;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic full, good, load, par_ok, frame_err, overrun;
  logic [1:0] after_data;
`ifdef PARITY_CHECK_EN
  logic par, parity_err;
  assign after_data = PARITY;
  assign par_ok = even_ok(32'(shreg), par);
  always_ff @(posedge clk)
    if (rst) begin
      par        <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par        <= state == PARITY ? bus.si : par;
      parity_err <= state == STOP && !par_ok;
    end
  assign bus.parity_err = parity_err;
`else
  assign after_data = STOP;
  assign par_ok = 1'b1;
  assign bus.parity_err = 1'b0;
`endif
  always_comb begin
    good = bus.si == STOP_BIT && par_ok;
    load = state == STOP && good && !full;
  end
  rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk(clk), .rst(rst), .load(load), .load_data(shreg), .out_ready(bus.out_ready),
    .out_data(bus.out_data), .out_valid(bus.out_valid), .full(full)
  );
  assign bus.busy      = state != IDLE;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= state == STOP && bus.si != STOP_BIT;
      overrun   <= state == STOP && good && full;
      case (state)
        IDLE: if (bus.si == START_BIT) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: begin
          shreg <= {shreg[DATA_W-2:0], bus.si};
          if (bit_cnt == CW'(DATA_W - 1)) state <= after_data;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: state <= STOP;
        default: state <= IDLE;
      endcase
    end
endmodule
